// File: rtl/oflow_mem_buffer_pkg.sv
// Shared types and widths for the MEM-buffer read consumer and its line buffer.
package oflow_mem_buffer_pkg;

    localparam int TOTAL_FRAME_NUM_WIDTH       = 8;
    localparam int OFFSET_WIDTH                = 10;
    localparam int NUM_OF_HISTORY_FRAMES_WIDTH = 3;
    localparam int BBOX_MAX_WIDTH              = 64;
    localparam int LINE_ENTRIES                = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        RD,
        WAIT_DATA,
        SEND,
        NEXT,
        DONE
    } rd_state_t;

    typedef struct packed {
        logic [BBOX_MAX_WIDTH-1:0] data;
        logic                      valid;
    } line_entry_t;

    // Saturating increment for the 2-bit settle/latency counters.
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/oflow_line_buf2.sv
// Two-entry line buffer: bulk load of one memory row, pop of the lowest valid entry.
module oflow_line_buf2
    import oflow_mem_buffer_pkg::*;
#(
    parameter int W = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic [LINE_ENTRIES-1:0][W-1:0] data,
    input  logic [LINE_ENTRIES-1:0]        vld,
    input  logic                           pop,
    output logic [W-1:0]                   out_data,
    output logic                           out_valid,
    output logic                           last,
    output logic                           empty
);

    line_entry_t entry_q [LINE_ENTRIES];
    logic        sel;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sel = 1'b1;
        if (entry_q[0].valid) begin
            sel = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    // NOTE: the entry array is reset because its valid bits gate downstream traffic and data is visible on bbox_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINE_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < LINE_ENTRIES; i++) begin
                entry_q[i].data  <= BBOX_MAX_WIDTH'(data[i]);
                entry_q[i].valid <= vld[i];
            end
        end else if (pop && out_valid) begin
            entry_q[sel].valid <= 1'b0;
        end
    end

    assign out_valid = entry_q[0].valid | entry_q[1].valid;
    assign empty     = ~out_valid;
    // Exactly one entry left: popping it empties the line.
    assign last      = entry_q[0].valid ^ entry_q[1].valid;
    assign out_data  = out_valid ? W'(entry_q[sel].data) : '0;

endmodule

// File: rtl/oflow_mem_buffer_read_consumer.sv
// Consumer end of the MEM-buffer read protocol: fetches each line from memory and
// streams its valid bboxes to the similarity-metric core over valid/ready.
module oflow_mem_buffer_read_consumer
    import oflow_mem_buffer_pkg::*;
#(
    parameter int BBOX_WIDTH  = 64,
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_SETTLE = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    output logic                                   start_read,
    input  logic                                   done_read,
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_to_read,
    input  logic [OFFSET_WIDTH-1:0]                offset_0_read,
    input  logic [OFFSET_WIDTH-1:0]                offset_1_read,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] counter_of_history_frame_to_interface,
    output logic                                   mem_rd_en,
    output logic [OFFSET_WIDTH-1:0]                mem_rd_addr_0,
    output logic [OFFSET_WIDTH-1:0]                mem_rd_addr_1,
    input  logic [BBOX_WIDTH-1:0]                  mem_rd_data_0,
    input  logic [BBOX_WIDTH-1:0]                  mem_rd_data_1,
    input  logic [1:0]                             mem_rd_valid,
    output logic                                   bbox_valid,
    input  logic                                   bbox_ready,
    output logic [BBOX_WIDTH-1:0]                  bbox_data,
    output logic [TOTAL_FRAME_NUM_WIDTH-1:0]       bbox_frame,
    output logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] bbox_hist_idx,
    output logic                                   ready_new_line,
    output logic                                   pass_done,
    output logic                                   busy
);

    localparam logic [1:0] SETTLE_LAST = 2'(ADDR_SETTLE - 1);
    localparam logic [1:0] LAT_LAST    = 2'(MEM_LATENCY - 1);

    rd_state_t             state_q, state_d;
    logic [1:0]            settle_cnt_q, lat_cnt_q;
    logic                  settle_end, lat_end;
    logic                  buf_load, buf_pop, buf_valid, buf_last, buf_empty;
    logic [BBOX_WIDTH-1:0] buf_data;

    assign settle_end = (settle_cnt_q == SETTLE_LAST);
    assign lat_end    = (lat_cnt_q == LAT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters restart from zero on every entry into their state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt_q <= 2'd0;
            lat_cnt_q    <= 2'd0;
        end else begin
            settle_cnt_q <= (state_q == SETTLE)    ? sat_inc2(settle_cnt_q) : 2'd0;
            lat_cnt_q    <= (state_q == WAIT_DATA) ? sat_inc2(lat_cnt_q)    : 2'd0;
        end
    end

    // Line descriptor is captured once the read FSM's outputs have settled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rd_addr_0 <= '0;
            mem_rd_addr_1 <= '0;
            bbox_frame    <= '0;
            bbox_hist_idx <= '0;
        end else if (state_q == SETTLE && settle_end && !done_read) begin
            mem_rd_addr_0 <= offset_0_read;
            mem_rd_addr_1 <= offset_1_read;
            bbox_frame    <= frame_to_read;
            bbox_hist_idx <= counter_of_history_frame_to_interface;
        end
    end

    always_comb begin
        state_d        = state_q;
        start_read     = 1'b0;
        mem_rd_en      = 1'b0;
        ready_new_line = 1'b0;
        pass_done      = 1'b0;
        buf_load       = 1'b0;
        buf_pop        = 1'b0;
        bbox_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_read = 1'b1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_end) begin
                    state_d = done_read ? DONE : RD;
                end
            end
            RD: begin
                mem_rd_en = 1'b1;
                state_d   = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (lat_end) begin
                    buf_load = 1'b1;
                    state_d  = (mem_rd_valid == 2'b00) ? NEXT : SEND;
                end
            end
            SEND: begin
                bbox_valid = buf_valid;
                if (buf_valid && bbox_ready) begin
                    buf_pop = 1'b1;
                    if (buf_last) begin
                        state_d = NEXT;
                    end
                end else if (buf_empty) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                ready_new_line = 1'b1;
                state_d        = SETTLE;
            end
            DONE: begin
                pass_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    oflow_line_buf2 #(
        .W(BBOX_WIDTH)
    ) u_line_buf (
        .clk      (clk),
        .reset    (reset),
        .load     (buf_load),
        .data     ({mem_rd_data_1, mem_rd_data_0}),
        .vld      (mem_rd_valid),
        .pop      (buf_pop),
        .out_data (buf_data),
        .out_valid(buf_valid),
        .last     (buf_last),
        .empty    (buf_empty)
    );

    assign bbox_data = buf_data;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_oflow_mem_buffer_read_consumer.sv
// Directed bench: emulates the read FSM and memory, checks the bbox stream against a queue model.
`timescale 1ns/1ps
module tb_oflow_mem_buffer_read_consumer;
    import oflow_mem_buffer_pkg::*;

    localparam int BW = 64;
    localparam int ML = 1;
    localparam int AS = 1;
    localparam int FW = TOTAL_FRAME_NUM_WIDTH;
    localparam int OW = OFFSET_WIDTH;
    localparam int HW = NUM_OF_HISTORY_FRAMES_WIDTH;

    typedef struct {
        logic [OW-1:0] o0;
        logic [OW-1:0] o1;
        logic [FW-1:0] fr;
        logic [HW-1:0] hi;
        logic [1:0]    vld;
        int            bp;
    } line_t;

    typedef struct {
        logic [BW-1:0] data;
        logic [FW-1:0] fr;
        logic [HW-1:0] hi;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, start, done_read, bbox_ready;
    logic [FW-1:0] frame_to_read;
    logic [OW-1:0] offset_0_read, offset_1_read;
    logic [HW-1:0] hist_in;
    logic [BW-1:0] mem_rd_data_0, mem_rd_data_1;
    logic [1:0]    mem_rd_valid;
    logic          start_read, mem_rd_en, bbox_valid, ready_new_line, pass_done, busy;
    logic [OW-1:0] mem_rd_addr_0, mem_rd_addr_1;
    logic [BW-1:0] bbox_data;
    logic [FW-1:0] bbox_frame;
    logic [HW-1:0] bbox_hist_idx;

    always #5 clk = ~clk;

    oflow_mem_buffer_read_consumer #(
        .BBOX_WIDTH(BW), .MEM_LATENCY(ML), .ADDR_SETTLE(AS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .start_read(start_read),
        .done_read(done_read), .frame_to_read(frame_to_read),
        .offset_0_read(offset_0_read), .offset_1_read(offset_1_read),
        .counter_of_history_frame_to_interface(hist_in),
        .mem_rd_en(mem_rd_en), .mem_rd_addr_0(mem_rd_addr_0), .mem_rd_addr_1(mem_rd_addr_1),
        .mem_rd_data_0(mem_rd_data_0), .mem_rd_data_1(mem_rd_data_1), .mem_rd_valid(mem_rd_valid),
        .bbox_valid(bbox_valid), .bbox_ready(bbox_ready), .bbox_data(bbox_data),
        .bbox_frame(bbox_frame), .bbox_hist_idx(bbox_hist_idx),
        .ready_new_line(ready_new_line), .pass_done(pass_done), .busy(busy)
    );

    // Memory contents are a fixed function of entry and row address.
    function automatic logic [BW-1:0] mem_word(input int sel, input logic [OW-1:0] a);
        logic [31:0] tag;
        tag = (sel == 0) ? 32'hA0A0_A0A0 : 32'hB0B0_B0B0;
        return {tag, 32'(a)};
    endfunction

    logic          pen [ML];
    logic [OW-1:0] pa0 [ML];
    logic [OW-1:0] pa1 [ML];
    logic [1:0]    cur_vld;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ML; i++) pen[i] <= 1'b0;
        end else begin
            pen[0] <= mem_rd_en;
            pa0[0] <= mem_rd_addr_0;
            pa1[0] <= mem_rd_addr_1;
            for (int i = 1; i < ML; i++) begin
                pen[i] <= pen[i-1];
                pa0[i] <= pa0[i-1];
                pa1[i] <= pa1[i-1];
            end
        end
    end

    assign mem_rd_data_0 = pen[ML-1] ? mem_word(0, pa0[ML-1]) : 64'hDEAD_BEEF_DEAD_BEEF;
    assign mem_rd_data_1 = pen[ML-1] ? mem_word(1, pa1[ML-1]) : 64'hDEAD_BEEF_DEAD_BEEF;
    assign mem_rd_valid  = pen[ML-1] ? cur_vld : 2'b00;

    line_t         lines [$];
    exp_t          exp_q [$];
    int            cum [$];
    logic [BW-1:0] hs_data [$];
    int            hs_hist [$];
    int            hs_cyc [$];
    int            n_checks = 0;
    int            n_err = 0;
    int            sr_cnt, rd_cnt, rnl_cnt, pd_cnt, hs_cnt;
    int            t_sr, t_rd, t_bv, t_pd, t_rnl;
    int            cyc_now = 0;
    bit            chk_en = 1'b0;
    bit            prev_v, prev_r, prev_hs;
    logic [BW-1:0] prev_d;
    logic [FW-1:0] prev_f;
    logic [HW-1:0] prev_h;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_line(input int o0, input int o1, input int fr, input int hi,
                            input logic [1:0] v, input int bp);
        line_t l;
        l.o0 = OW'(o0); l.o1 = OW'(o1); l.fr = FW'(fr); l.hi = HW'(hi); l.vld = v; l.bp = bp;
        lines.push_back(l);
    endtask

    task automatic init_model();
        int   total;
        exp_t e;
        total = 0;
        exp_q.delete(); cum.delete(); hs_data.delete(); hs_hist.delete(); hs_cyc.delete();
        sr_cnt = 0; rd_cnt = 0; rnl_cnt = 0; pd_cnt = 0; hs_cnt = 0;
        t_sr = -1; t_rd = -1; t_bv = -1; t_pd = -1; t_rnl = -1;
        foreach (lines[i]) begin
            for (int s = 0; s < 2; s++) begin
                if (lines[i].vld[s]) begin
                    e.data = mem_word(s, (s == 0) ? lines[i].o0 : lines[i].o1);
                    e.fr   = lines[i].fr;
                    e.hi   = lines[i].hi;
                    exp_q.push_back(e);
                    total++;
                end
            end
            cum.push_back(total);
        end
    endtask

    task automatic present(input int k);
        if (k < lines.size()) begin
            done_read     = 1'b0;
            offset_0_read = lines[k].o0;
            offset_1_read = lines[k].o1;
            frame_to_read = lines[k].fr;
            hist_in       = lines[k].hi;
            cur_vld       = lines[k].vld;
        end else begin
            done_read = 1'b1;
        end
    endtask

    // Per-cycle compare against the model, mid-cycle after the driver has settled inputs.
    always @(negedge clk) begin
        #2;
        cyc_now++;
        if (!reset && chk_en) begin
            if (start_read) begin
                sr_cnt++;
                if (t_sr < 0) t_sr = cyc_now;
            end
            if (mem_rd_en) begin
                if (rd_cnt < lines.size()) begin
                    check("rd_addr_0", 64'(mem_rd_addr_0), 64'(lines[rd_cnt].o0));
                    check("rd_addr_1", 64'(mem_rd_addr_1), 64'(lines[rd_cnt].o1));
                end else begin
                    check("rd_unexpected", 64'd1, 64'd0);
                end
                if (t_rd < 0) t_rd = cyc_now;
                rd_cnt++;
            end
            if (prev_v && !prev_r) begin
                check("hold_valid", 64'(bbox_valid), 64'd1);
                check("hold_data", bbox_data, prev_d);
                check("hold_frame", 64'(bbox_frame), 64'(prev_f));
                check("hold_hist", 64'(bbox_hist_idx), 64'(prev_h));
            end
            if (bbox_valid) begin
                if (t_bv < 0) t_bv = cyc_now;
                if (bbox_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_bbox", 64'd1, 64'd0);
                    end else begin
                        check("bbox_data", bbox_data, exp_q[0].data);
                        check("bbox_frame", 64'(bbox_frame), 64'(exp_q[0].fr));
                        check("bbox_hist", 64'(bbox_hist_idx), 64'(exp_q[0].hi));
                        void'(exp_q.pop_front());
                    end
                    hs_data.push_back(bbox_data);
                    hs_hist.push_back(int'(bbox_hist_idx));
                    hs_cyc.push_back(cyc_now);
                    hs_cnt++;
                end
            end
            if (ready_new_line) begin
                if (t_rnl < 0) t_rnl = cyc_now;
                if (rnl_cnt < cum.size()) begin
                    check("rnl_after_line", 64'(hs_cnt), 64'(cum[rnl_cnt]));
                    if (cum[rnl_cnt] != ((rnl_cnt > 0) ? cum[rnl_cnt-1] : 0))
                        check("rnl_follows_hs", 64'(prev_hs), 64'd1);
                end else begin
                    check("rnl_unexpected", 64'd1, 64'd0);
                end
                rnl_cnt++;
            end
            if (pass_done) begin
                pd_cnt++;
                t_pd = cyc_now;
            end
            prev_v  = bbox_valid;
            prev_r  = bbox_ready;
            prev_hs = bbox_valid && bbox_ready;
            prev_d  = bbox_data;
            prev_f  = bbox_frame;
            prev_h  = bbox_hist_idx;
        end else begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end
    end

    task automatic run_pass(input bit inject, input bit start_at_done);
        int k;
        int bp_left;
        bit finished;
        k = 0;
        finished = 1'b0;
        init_model();
        present(0);
        bp_left = (lines.size() > 0) ? lines[0].bp : 0;
        bbox_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start = inject && (cyc == 4);
            if (ready_new_line) begin
                k++;
                present(k);
                bp_left = (k < lines.size()) ? lines[k].bp : 0;
            end
            if (bbox_valid && bp_left > 0) begin
                bbox_ready = 1'b0;
                bp_left--;
            end else begin
                bbox_ready = 1'b1;
            end
            if (pass_done) begin
                finished = 1'b1;
                start = start_at_done;
                break;
            end
        end
        check("pass_finished", 64'(finished), 64'd1);
        @(negedge clk);
        start = 1'b0;
        done_read = 1'b0;
        check("idle_after_pass", 64'(busy), 64'd0);
        check("start_read_cnt", 64'(sr_cnt), 64'd1);
        check("pass_done_cnt", 64'(pd_cnt), 64'd1);
        check("rnl_cnt", 64'(rnl_cnt), 64'(lines.size()));
        check("rd_cnt", 64'(rd_cnt), 64'(lines.size()));
        check("model_drained", 64'(exp_q.size()), 64'd0);
        if (lines.size() > 0) begin
            check("lat_addr", 64'(t_rd - t_sr), 64'(1 + AS));
            if (lines[0].vld != 2'b00)
                check("lat_first_bbox", 64'(t_bv - t_sr), 64'(2 + AS + ML));
        end else begin
            check("lat_empty_done", 64'(t_pd - t_sr), 64'(1 + AS));
            check("empty_no_bbox", 64'(hs_cnt), 64'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_start_read"}, 64'(start_read), 64'd0);
        check({tag, "_mem_rd_en"}, 64'(mem_rd_en), 64'd0);
        check({tag, "_addrs"}, 64'({mem_rd_addr_1, mem_rd_addr_0}), 64'd0);
        check({tag, "_bbox_valid"}, 64'(bbox_valid), 64'd0);
        check({tag, "_bbox_data"}, bbox_data, 64'd0);
        check({tag, "_frame_hist"}, 64'({bbox_frame, bbox_hist_idx}), 64'd0);
        check({tag, "_rnl_done"}, 64'({ready_new_line, pass_done}), 64'd0);
    endtask

    int exp_hist [6] = '{0, 0, 1, 1, 2, 2};

    initial begin
        bit reached;
        reset = 1'b1; start = 1'b0; done_read = 1'b0; bbox_ready = 1'b1;
        frame_to_read = '0; offset_0_read = '0; offset_1_read = '0; hist_in = '0; cur_vld = 2'b00;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        // Single line, both entries, plus a start that lands on the pass_done cycle.
        lines.delete();
        add_line(5, 6, 7, 2, 2'b11, 0);
        run_pass(1'b0, 1'b1);
        check("single_hs_cnt", 64'(hs_data.size()), 64'd2);
        if (hs_data.size() >= 2) begin
            check("single_a", hs_data[0], 64'hA0A0_A0A0_0000_0005);
            check("single_b", hs_data[1], 64'hB0B0_B0B0_0000_0006);
            check("single_no_bubble", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
        end

        // Last row of an odd frame: only entry 0 occupied.
        lines.delete();
        add_line(9, 10, 3, 1, 2'b01, 0);
        run_pass(1'b0, 1'b0);
        check("odd_hs_cnt", 64'(hs_data.size()), 64'd1);
        if (hs_data.size() >= 1) begin
            check("odd_c", hs_data[0], 64'hA0A0_A0A0_0000_0009);
            check("odd_rnl_gap", 64'(t_rnl - hs_cyc[0]), 64'd1);
        end

        // Backpressure: four stalled cycles on entry 0.
        lines.delete();
        add_line(12, 13, 4, 0, 2'b11, 4);
        run_pass(1'b0, 1'b0);
        check("bp_hs_cnt", 64'(hs_data.size()), 64'd2);
        if (hs_data.size() >= 2) begin
            check("bp_stall_len", 64'(hs_cyc[0] - t_bv), 64'd4);
            check("bp_second_next", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
        end

        // Three lines across history frames, with a start pulse while busy.
        lines.delete();
        add_line(30, 31, 20, 0, 2'b11, 0);
        add_line(32, 33, 21, 1, 2'b11, 0);
        add_line(34, 35, 22, 2, 2'b11, 0);
        run_pass(1'b1, 1'b0);
        check("multi_hs_cnt", 64'(hs_hist.size()), 64'd6);
        if (hs_hist.size() >= 6) begin
            for (int i = 0; i < 6; i++) check("multi_hist_order", 64'(hs_hist[i]), 64'(exp_hist[i]));
            check("multi_last_data", hs_data[5], 64'hB0B0_B0B0_0000_0023);
        end

        // Empty pass: done_read at the first sample.
        lines.delete();
        run_pass(1'b0, 1'b0);

        // Reset while a bbox is being presented.
        lines.delete();
        add_line(40, 41, 5, 3, 2'b11, 0);
        init_model();
        present(0);
        bbox_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bbox_valid) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reached_send", 64'(reached), 64'd1);
        #1 reset = 1'b1;
        #1 check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        bbox_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_pass_done", 64'(pd_cnt), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        // Clean pass after the abort.
        lines.delete();
        add_line(5, 6, 7, 2, 2'b11, 0);
        run_pass(1'b0, 1'b0);
        check("post_reset_hs_cnt", 64'(hs_data.size()), 64'd2);
        if (hs_data.size() >= 1) check("post_reset_a", hs_data[0], 64'hA0A0_A0A0_0000_0005);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
